// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared widths, register-number constants and bypass helper for the WB register file.
package wb_regfile_pkg;
    localparam int DATA_W  = 32;
    localparam int RADDR_W = 5;
    localparam int NREGS   = 32;
    localparam logic [RADDR_W-1:0] REG_ZERO = 5'd0;

    typedef logic [DATA_W-1:0]  word_t;
    typedef logic [RADDR_W-1:0] raddr_t;

    function automatic logic wr_hit(input logic we, input raddr_t wn, input raddr_t rn);
        return we && (wn != REG_ZERO) && (rn == wn);
    endfunction
endpackage

// File: rtl/wb_regfile_mux.sv
// wb_mux: 2:1 write-back select between ALU result and load data.
module wb_mux
    import wb_regfile_pkg::*;
(
    input  logic  sel,
    input  word_t a,
    input  word_t b,
    output word_t y
);
    assign y = sel ? b : a;
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: 31x32 register file with WB-stage select, write-before-read bypass and commit counter.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter bit CNT_EN = 1'b1
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic [DATA_W-1:0]  wb_Alu_Result,
    input  logic [DATA_W-1:0]  wb_mo,
    input  logic               wb_m2reg,
    input  logic               wb_wreg,
    input  logic [RADDR_W-1:0] wb_rn,
    input  logic [RADDR_W-1:0] rna,
    input  logic [RADDR_W-1:0] rnb,
    output logic [DATA_W-1:0]  qa,
    output logic [DATA_W-1:0]  qb,
    output logic [DATA_W-1:0]  wb_data,
    output logic [DATA_W-1:0]  wb_cnt
);
    word_t regs [1:NREGS-1];
    word_t cnt_q;
    word_t rd_a;
    word_t rd_b;
    logic  commit;

    wb_mux u_wb_mux (
        .sel (wb_m2reg),
        .a   (wb_Alu_Result),
        .b   (wb_mo),
        .y   (wb_data)
    );

    assign commit = wb_wreg && (wb_rn != REG_ZERO);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 1; i < NREGS; i++) regs[i] <= '0;
        end else if (commit) begin
            regs[wb_rn] <= wb_data;
        end
    end

    generate
        if (CNT_EN) begin : g_cnt
            always_ff @(posedge clk or negedge clrn) begin
                if (!clrn) cnt_q <= '0;
                else if (commit) cnt_q <= cnt_q + 1'b1;
            end
        end else begin : g_no_cnt
            assign cnt_q = '0;
        end
    endgenerate

    // register 0 is not stored; its read is forced to zero before the bypass check
    always_comb begin
        rd_a = (rna == REG_ZERO) ? '0 : regs[rna];
        rd_b = (rnb == REG_ZERO) ? '0 : regs[rnb];
        qa   = wr_hit(wb_wreg, wb_rn, rna) ? wb_data : rd_a;
        qb   = wr_hit(wb_wreg, wb_rn, rnb) ? wb_data : rd_b;
    end

    assign wb_cnt = cnt_q;
endmodule
